// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
// Definitions shared by the ALU execute-stage controller, its interface and
// its predicate checker: opcode and condition-code constants, flag bit
// indices, predicate encodings and the controller state enum.
// Optional feature macro used elsewhere: ALU_EXEC_DOUBLE_EN.
// -----------------------------------------------------------------------------
package alu_exec_pkg;

    localparam int OP_BITS   = 5;
    localparam int COND_BITS = 4;
    localparam int FLG_BITS  = 5;

    // Opcodes (octal). Ops 20..37 only modify P and never write back.
    localparam logic [4:0] OP_MOV   = 5'o00;
    localparam logic [4:0] OP_AND   = 5'o01;
    localparam logic [4:0] OP_OR    = 5'o02;
    localparam logic [4:0] OP_XOR   = 5'o03;
    localparam logic [4:0] OP_ADD   = 5'o04;
    localparam logic [4:0] OP_ADK   = 5'o05;
    localparam logic [4:0] OP_SUB   = 5'o06;
    localparam logic [4:0] OP_SBK   = 5'o07;
    localparam logic [4:0] OP_NOT   = 5'o10;
    localparam logic [4:0] OP_SHL   = 5'o11;
    localparam logic [4:0] OP_SHR   = 5'o12;
    localparam logic [4:0] OP_ASR   = 5'o13;
    localparam logic [4:0] OP_PBASE = 5'o20;

    // Condition codes
    localparam logic [3:0] COND_AL = 4'h0;
    localparam logic [3:0] COND_EQ = 4'h1;
    localparam logic [3:0] COND_NE = 4'h2;
    localparam logic [3:0] COND_CS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_MI = 4'h5;
    localparam logic [3:0] COND_PL = 4'h6;
    localparam logic [3:0] COND_VS = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;

    // Flag register bit positions {P,V,K,S,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_S = 1;
    localparam int FLG_K = 2;
    localparam int FLG_V = 3;
    localparam int FLG_P = 4;

    // Predicate encodings
    localparam logic [1:0] PRED_ALWAYS = 2'b00;
    localparam logic [1:0] PRED_IF_P   = 2'b01;
    localparam logic [1:0] PRED_IF_NP  = 2'b10;
    localparam logic [1:0] PRED_NEVER  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC_LO = 3'd1,
        ST_WB_LO   = 3'd2,
        ST_EXEC_HI = 3'd3,
        ST_WB_HI   = 3'd4
    } state_t;

    // Add/subtract family (04..07): the only ops that can be chained into a
    // 24-bit double.
    function automatic logic is_chain_op(input logic [4:0] op);
        return (op[4:2] == 3'b001);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl_if
// Decoded-instruction input port and register-file writeback port of the
// ALU execute controller.
//   master : decoder / register-file side (drives in_*, wb_ready)
//   slave  : controller side (drives in_ready, wb_valid, wb_dst, wb_data)
// in_ah/in_bh/in_dbl are only consumed when ALU_EXEC_DOUBLE_EN is defined.
// -----------------------------------------------------------------------------
interface alu_exec_ctrl_if
    import alu_exec_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DST_BITS = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_BITS-1:0]   in_op;
    logic [COND_BITS-1:0] in_cond;
    logic [1:0]           in_pred;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [WIDTH-1:0]     in_ah;
    logic [WIDTH-1:0]     in_bh;
    logic                 in_dbl;
    logic [DST_BITS-1:0]  in_dst;

    logic                 wb_valid;
    logic [DST_BITS-1:0]  wb_dst;
    logic [WIDTH-1:0]     wb_data;
    logic                 wb_ready;

    modport master (
        output in_valid, in_op, in_cond, in_pred, in_a, in_b, in_ah, in_bh,
               in_dbl, in_dst, wb_ready,
        input  in_ready, wb_valid, wb_dst, wb_data
    );

    modport slave (
        input  in_valid, in_op, in_cond, in_pred, in_a, in_b, in_ah, in_bh,
               in_dbl, in_dst, wb_ready,
        output in_ready, wb_valid, wb_dst, wb_data
    );
endinterface

// File: rtl/alu_exec_ctrl_pred_check.sv
// -----------------------------------------------------------------------------
// alu_pred_check
// Combinational predicate evaluation.
//   pred    in  2  predicate encoding (always / if P / if not P / never)
//   p_flag  in  1  current P flag
//   execute out 1  instruction should run
// -----------------------------------------------------------------------------
module alu_pred_check
    import alu_exec_pkg::*;
(
    input  logic [1:0] pred,
    input  logic       p_flag,
    output logic       execute
);
    always_comb begin
        execute = 1'b0;
        case (pred)
            PRED_ALWAYS: execute = 1'b1;
            PRED_IF_P:   execute = p_flag;
            PRED_IF_NP:  execute = ~p_flag;
            default:     execute = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
// Execute-stage controller for a combinational 12-bit ALU. Accepts one decoded
// instruction per handshake, applies predication against P, drives the ALU,
// owns the {P,V,K,S,Z} flag register and writes results back to the register
// file over a valid/ready port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus (slave)              instruction input + writeback port
//   alu_a/alu_b/alu_op/
//   alu_cond/alu_flg         registered ALU drive (alu_flg = flag register)
//   alu_q/alu_flg_res        ALU result and flag output
//   flags                    architectural flag register
// Define ALU_EXEC_DOUBLE_EN to build 24-bit add/sub as two chained beats
// (EXEC_HI/WB_HI); otherwise in_dbl/in_ah/in_bh are ignored.
// -----------------------------------------------------------------------------
module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DST_BITS = 3
)(
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_ctrl_if.slave       bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [OP_BITS-1:0]   alu_op,
    output logic [COND_BITS-1:0] alu_cond,
    output logic [FLG_BITS-1:0]  alu_flg,
    input  logic [WIDTH-1:0]     alu_q,
    input  logic [FLG_BITS-1:0]  alu_flg_res,
    output logic [FLG_BITS-1:0]  flags
);
    state_t                state_q, state_d;

    // Latched instruction fields
    logic                  pop_q, pop_d;      // P-modifying op: no writeback
    logic [DST_BITS-1:0]   dst_q, dst_d;

    // Registered outputs
    logic [WIDTH-1:0]      alu_a_q, alu_a_d;
    logic [WIDTH-1:0]      alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]    alu_op_q, alu_op_d;
    logic [COND_BITS-1:0]  alu_cond_q, alu_cond_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DST_BITS-1:0]   wb_dst_q, wb_dst_d;
    logic [WIDTH-1:0]      wb_data_q, wb_data_d;
    logic [FLG_BITS-1:0]   flags_q, flags_d;

    logic                  in_ready;
    logic                  pred_ok;
    logic                  issue;
    logic                  dbl_active;

`ifdef ALU_EXEC_DOUBLE_EN
    logic [OP_BITS-1:0]    op_q, op_d;
    logic [COND_BITS-1:0]  cond_q, cond_d;
    logic [WIDTH-1:0]      ah_q, ah_d;
    logic [WIDTH-1:0]      bh_q, bh_d;
    logic                  dbl_q, dbl_d;
    localparam logic [DST_BITS-1:0] DST_ONE = 1;

    assign dbl_active = dbl_q;
`else
    logic                  unused_dbl;

    assign dbl_active = 1'b0;
    assign unused_dbl = ^{bus.in_dbl, bus.in_ah, bus.in_bh};
`endif

    // Only the idle state accepts; reset forces not-ready even in IDLE.
    assign in_ready = (state_q == ST_IDLE) & ~rst;

    alu_pred_check u_pred (
        .pred    (bus.in_pred),
        .p_flag  (flags_q[FLG_P]),
        .execute (pred_ok)
    );

    // A skipped instruction is consumed by the handshake but never leaves IDLE.
    assign issue = bus.in_valid & in_ready & pred_ok;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (issue) state_d = ST_EXEC_LO;
            ST_EXEC_LO: state_d = pop_q ? ST_IDLE : ST_WB_LO;
            ST_WB_LO:   if (bus.wb_ready) state_d = dbl_active ? ST_EXEC_HI : ST_IDLE;
`ifdef ALU_EXEC_DOUBLE_EN
            ST_EXEC_HI: state_d = ST_WB_HI;
            ST_WB_HI:   if (bus.wb_ready) state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        pop_d = pop_q;
        dst_d = dst_q;
`ifdef ALU_EXEC_DOUBLE_EN
        op_d   = op_q;
        cond_d = cond_q;
        ah_d   = ah_q;
        bh_d   = bh_q;
        dbl_d  = dbl_q;
`endif
        if (issue) begin
            pop_d = bus.in_op[4];
            dst_d = bus.in_dst;
`ifdef ALU_EXEC_DOUBLE_EN
            op_d   = bus.in_op;
            cond_d = bus.in_cond;
            ah_d   = bus.in_ah;
            bh_d   = bus.in_bh;
            dbl_d  = bus.in_dbl & is_chain_op(bus.in_op);
`endif
        end

        // ALU drive is registered, so it is computed from the state being
        // entered. EXEC_LO is only entered straight from an accept, so the
        // low operands come from the bus and need no holding register.
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_op_d   = OP_MOV;
        alu_cond_d = COND_AL;
        case (state_d)
            ST_EXEC_LO: begin
                alu_a_d    = bus.in_a;
                alu_b_d    = bus.in_b;
                alu_op_d   = bus.in_op;
                alu_cond_d = bus.in_cond;
            end
`ifdef ALU_EXEC_DOUBLE_EN
            ST_EXEC_HI: begin
                // High beat always uses the carry-in form (ADD->ADK, SUB->SBK).
                alu_a_d    = ah_q;
                alu_b_d    = bh_q;
                alu_op_d   = {op_q[4:1], 1'b1};
                alu_cond_d = cond_q;
            end
`endif
            default: ;
        endcase

        wb_valid_d = (state_d == ST_WB_LO);
        wb_dst_d   = wb_dst_q;
        if (state_d == ST_WB_LO) begin
            wb_dst_d = dst_q;
        end
`ifdef ALU_EXEC_DOUBLE_EN
        if (state_d == ST_WB_HI) begin
            wb_valid_d = 1'b1;
            wb_dst_d   = dst_q + DST_ONE;
        end
`endif

        // Result and flags are captured at the end of every EXEC cycle.
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
        if ((state_q == ST_EXEC_LO) || (state_q == ST_EXEC_HI)) begin
            wb_data_d = alu_q;
            flags_d   = alu_flg_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q      <= 1'b0;
            dst_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_MOV;
            alu_cond_q <= COND_AL;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
`ifdef ALU_EXEC_DOUBLE_EN
            op_q       <= OP_MOV;
            cond_q     <= COND_AL;
            ah_q       <= '0;
            bh_q       <= '0;
            dbl_q      <= 1'b0;
`endif
        end else begin
            pop_q      <= pop_d;
            dst_q      <= dst_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_cond_q <= alu_cond_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
`ifdef ALU_EXEC_DOUBLE_EN
            op_q       <= op_d;
            cond_q     <= cond_d;
            ah_q       <= ah_d;
            bh_q       <= bh_d;
            dbl_q      <= dbl_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_dst   = wb_dst_q;
    assign bus.wb_data  = wb_data_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_cond     = alu_cond_q;
    assign alu_flg      = flags_q;
    assign flags        = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
`timescale 1ns/1ps
module tb_alu_exec_ctrl;
    import alu_exec_pkg::*;

    localparam int W = 12;
    localparam int D = 3;
`ifdef ALU_EXEC_DOUBLE_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_ctrl_if #(.WIDTH(W), .DST_BITS(D)) bus ();

    logic [W-1:0] alu_a, alu_b, alu_q;
    logic [4:0]   alu_op, alu_flg, alu_flg_res, flags;
    logic [3:0]   alu_cond;

    alu_exec_ctrl #(.WIDTH(W), .DST_BITS(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cond    (alu_cond),
        .alu_flg     (alu_flg),
        .alu_q       (alu_q),
        .alu_flg_res (alu_flg_res),
        .flags       (flags)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference 12-bit ALU: returns {flags, result}.
    function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [11:0] a,
                                           input logic [11:0] b, input logic [4:0] f);
        logic [12:0] s;
        logic [11:0] q;
        logic [4:0]  nf;
        logic        c;
        nf = f;
        q  = '0;
        s  = '0;
        c  = 1'b0;
        if (op[4]) begin
            q = a - b;
            nf[FLG_P] = (q == 12'h000);
        end else begin
            case (op)
                OP_MOV: q = b;
                OP_AND: q = a & b;
                OP_OR:  q = a | b;
                OP_XOR: q = a ^ b;
                OP_ADD, OP_ADK: begin
                    c = (op == OP_ADK) ? f[FLG_K] : 1'b0;
                    s = {1'b0, a} + {1'b0, b} + {12'b0, c};
                    q = s[11:0];
                    nf[FLG_K] = s[12];
                    nf[FLG_V] = (a[11] == b[11]) && (q[11] != a[11]);
                end
                OP_SUB, OP_SBK: begin
                    c = (op == OP_SBK) ? f[FLG_K] : 1'b0;
                    s = {1'b0, a} - {1'b0, b} - {12'b0, c};
                    q = s[11:0];
                    nf[FLG_K] = s[12];
                    nf[FLG_V] = (a[11] != b[11]) && (q[11] != a[11]);
                end
                OP_NOT: q = ~a;
                default: q = a;
            endcase
            nf[FLG_S] = q[11];
            nf[FLG_Z] = ((op == OP_ADK) || (op == OP_SBK)) ? (f[FLG_Z] && (q == 12'h000))
                                                           : (q == 12'h000);
        end
        return {nf, q};
    endfunction

    always_comb begin
        {alu_flg_res, alu_q} = alu_fn(alu_op, alu_a, alu_b, alu_flg);
    end

    // Transaction model: expected writeback beats and final flag register.
    typedef struct packed {
        logic [2:0]  dst;
        logic [11:0] data;
    } beat_t;
    beat_t      exp_q[$];
    logic [4:0] mflags;

    // Per-cycle compare: every visible beat must match the model's next beat.
    always @(negedge clk) begin
        check("alu_flg_mirror", alu_flg, flags);
        if (bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", bus.wb_valid, 1'b0);
            end else begin
                check("wb_dst", bus.wb_dst, exp_q[0].dst);
                check("wb_data", bus.wb_data, exp_q[0].data);
                if (bus.wb_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [3:0] cond, input logic [1:0] pred,
                         input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] ah, input logic [11:0] bh,
                         input logic dbl, input logic [2:0] dst);
        logic [16:0] r;
        logic        run;
        logic [2:0]  dst_hi;
        int          n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_ready", bus.in_ready, 1'b1);
        case (pred)
            2'b00:   run = 1'b1;
            2'b01:   run = mflags[FLG_P];
            2'b10:   run = !mflags[FLG_P];
            default: run = 1'b0;
        endcase
        if (run) begin
            r = alu_fn(op, a, b, mflags);
            mflags = r[16:12];
            if (!op[4]) begin
                exp_q.push_back(beat_t'{dst, r[11:0]});
                if (DBL_EN && dbl && (op >= OP_ADD) && (op <= OP_SBK)) begin
                    r = alu_fn(op | 5'o01, ah, bh, mflags);
                    mflags = r[16:12];
                    dst_hi = dst + 3'd1;
                    exp_q.push_back(beat_t'{dst_hi, r[11:0]});
                end
            end
        end
        bus.in_op    = op;
        bus.in_cond  = cond;
        bus.in_pred  = pred;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_ah    = ah;
        bus.in_bh    = bh;
        bus.in_dbl   = dbl;
        bus.in_dst   = dst;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_instr(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, bus.in_ready, 1'b1);
        check({tag, "_flags"}, flags, mflags);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_cond  = '0;
        bus.in_pred  = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_ah    = '0;
        bus.in_bh    = '0;
        bus.in_dbl   = 1'b0;
        bus.in_dst   = '0;
        bus.wb_ready = 1'b1;
        mflags       = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_wb_dst", bus.wb_dst, 3'd0);
        check("rst_wb_data", bus.wb_data, 12'h000);
        check("rst_alu_op", alu_op, 5'o00);
        check("rst_alu_cond", alu_cond, 4'h0);
        check("rst_alu_a", alu_a, 12'h000);
        check("rst_alu_b", alu_b, 12'h000);
        check("rst_flags", flags, 5'b00000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // ADD 0x7FF+0x001 -> 0x800 to r3 at T0+2; V=1 S=1
        issue(OP_ADD, COND_EQ, PRED_ALWAYS, 12'h7FF, 12'h001, 12'h0, 12'h0, 1'b0, 3'd3);
        check("t1_exec_op", alu_op, OP_ADD);
        check("t1_exec_cond", alu_cond, COND_EQ);
        check("t1_exec_a", alu_a, 12'h7FF);
        check("t1_exec_b", alu_b, 12'h001);
        check("t1_exec_nowb", bus.wb_valid, 1'b0);
        @(posedge clk); #1;
        check("t1_wb_valid", bus.wb_valid, 1'b1);
        check("t1_wb_data", bus.wb_data, 12'h800);
        check("t1_wb_dst", bus.wb_dst, 3'd3);
        finish_instr("t1");
        check("t1_flags_lit", flags, 5'b01010);

        // SUB 0x000-0x001 -> 0xFFF; K=1 S=1
        issue(OP_SUB, COND_AL, PRED_ALWAYS, 12'h000, 12'h001, 12'h0, 12'h0, 1'b0, 3'd1);
        @(posedge clk); #1;
        check("t2_wb_data", bus.wb_data, 12'hFFF);
        finish_instr("t2");
        check("t2_flags_lit", flags, 5'b00110);

        // pred=01 with P=0: skipped, no ALU op, stays ready
        issue(OP_ADD, COND_AL, PRED_IF_P, 12'h111, 12'h222, 12'h0, 12'h0, 1'b0, 3'd2);
        check("skip_in_ready", bus.in_ready, 1'b1);
        check("skip_wb_valid", bus.wb_valid, 1'b0);
        check("skip_alu_op", alu_op, 5'o00);
        check("skip_flags_lit", flags, 5'b00110);
        @(posedge clk); #1;
        check("skip_wb_valid2", bus.wb_valid, 1'b0);
        finish_instr("skip");

        // Double ADD: lo 0xFFF+0x001, hi 0x000+0x000, dst 7
        issue(OP_ADD, COND_AL, PRED_ALWAYS, 12'hFFF, 12'h001, 12'h000, 12'h000, 1'b1, 3'd7);
        @(posedge clk); #1;
        check("dbl_lo_data", bus.wb_data, 12'h000);
        check("dbl_lo_dst", bus.wb_dst, 3'd7);
`ifdef ALU_EXEC_DOUBLE_EN
        @(posedge clk); #1;
        check("dbl_hi_op", alu_op, OP_ADK);
        @(posedge clk); #1;
        check("dbl_hi_data", bus.wb_data, 12'h001);
        check("dbl_hi_dst", bus.wb_dst, 3'd0);
        finish_instr("dbl");
        check("dbl_flag_k", flags[FLG_K], 1'b0);
        check("dbl_flag_z", flags[FLG_Z], 1'b0);
`else
        finish_instr("dbl");
        check("dbl_single_flags", flags, 5'b00101);
`endif

        // Writeback stall: wb_ready low 3 cycles in WB_LO
        bus.wb_ready = 1'b0;
        issue(OP_ADD, COND_AL, PRED_ALWAYS, 12'h123, 12'h456, 12'h0, 12'h0, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_wb_valid", bus.wb_valid, 1'b1);
            check("stall_wb_data", bus.wb_data, 12'h579);
            check("stall_wb_dst", bus.wb_dst, 3'd2);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_alu_op", alu_op, 5'o00);
        end
        bus.wb_ready = 1'b1;
        finish_instr("stall");

        // P-op with zero result sets P, no writeback, ready at T0+2
        issue(OP_PBASE, COND_AL, PRED_ALWAYS, 12'h005, 12'h005, 12'h0, 12'h0, 1'b0, 3'd6);
        check("pop_exec_op", alu_op, OP_PBASE);
        check("pop_busy", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        check("pop_ready", bus.in_ready, 1'b1);
        check("pop_p_flag", flags[FLG_P], 1'b1);
        check("pop_wb_valid", bus.wb_valid, 1'b0);
        finish_instr("pop");

        // Predicate variants with P=1, then with P cleared
        issue(OP_XOR, COND_NE, PRED_IF_P,  12'h0F0, 12'h0FF, 12'h0, 12'h0, 1'b0, 3'd4);
        finish_instr("p1_exec");
        issue(OP_ADD, COND_AL, PRED_IF_NP, 12'h001, 12'h001, 12'h0, 12'h0, 1'b0, 3'd5);
        finish_instr("p1_skip");
        issue(OP_SUB, COND_AL, PRED_NEVER, 12'h001, 12'h001, 12'h0, 12'h0, 1'b0, 3'd5);
        finish_instr("never");
        issue(OP_OR,  COND_AL, PRED_ALWAYS, 12'hA00, 12'h00B, 12'h777, 12'h777, 1'b1, 3'd6);
        finish_instr("dbl_ignored");
        issue(OP_PBASE, COND_AL, PRED_ALWAYS, 12'h001, 12'h002, 12'h0, 12'h0, 1'b0, 3'd0);
        finish_instr("pop_clr");
        issue(OP_ADD, COND_AL, PRED_IF_NP, 12'h800, 12'h800, 12'h0, 12'h0, 1'b0, 3'd5);
        finish_instr("p0_exec");
        issue(OP_SUB, COND_AL, PRED_ALWAYS, 12'h005, 12'h002, 12'h000, 12'h001, 1'b1, 3'd3);
        finish_instr("dbl_sub");

        // Reset while an instruction is in flight drops it completely
`ifdef ALU_EXEC_DOUBLE_EN
        issue(OP_ADD, COND_AL, PRED_ALWAYS, 12'h801, 12'h801, 12'h002, 12'h003, 1'b1, 3'd5);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("rst_hi_op", alu_op, OP_ADK);
`else
        issue(OP_ADD, COND_AL, PRED_ALWAYS, 12'h801, 12'h801, 12'h002, 12'h003, 1'b0, 3'd5);
        check("rst_lo_op", alu_op, OP_ADD);
`endif
        rst = 1'b1;
        exp_q.delete();
        mflags = '0;
        @(posedge clk); #1;
        check("mid_rst_flags", flags, 5'b00000);
        check("mid_rst_wb_valid", bus.wb_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_rst_in_ready", bus.in_ready, 1'b1);
        check("after_rst_flags", flags, 5'b00000);
        repeat (3) @(posedge clk);
        #1;
        check("after_rst_no_wb", bus.wb_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
